lsu_out: RTL and testbench

Response stage of the load/store unit, directly downstream of the LSU request register stage that drives `data_we_o`, `data_wdata_o` and `data_addr_o` toward memory. It records the attributes of each issued access and waits for the memory response, merging two beats for a misaligned access. It then aligns and sign- or zero-extends load data and holds the result for writeback under a valid/ready handshake. The block supports one access in flight and reports bus errors.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_rdata_align.sv | 34 +++
 rtl/lsu_out.sv | 128 ++++++++++++
 tb/tb_lsu_out.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and the misalignment predicate for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT_LO = 2'b01,
        ST_WAIT_HI = 2'b10,
        ST_HOLD    = 2'b11
    } lsu_out_state_e;

    // Reserved type 2'b11 behaves as a word access.
    function automatic logic lsu_is_split(input logic [1:0] typ, input logic [1:0] offset);
        logic is_word;
        is_word = (typ != HALF) && (typ != BYTE);
        return (is_word && (offset != 2'd0)) || ((typ == HALF) && (offset == 2'd3));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_rdata_align.sv
// ============================================================================
// Module      : lsu_rdata_align
// Description : Aligns a two-word response window and extends sub-word loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_rdata_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  offset,
    input  logic [1:0]  typ,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [31:0] w_win;

    assign w_win = 32'({hi, lo} >> {offset, 3'b000});

    always_comb begin
        result = w_win;
        if (typ == BYTE) begin
            result = {{24{sign_ext & w_win[7]}}, w_win[7:0]};
        end else if (typ == HALF) begin
            result = {{16{sign_ext & w_win[15]}}, w_win[15:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_out.sv
// ============================================================================
// Module      : lsu_out
// Description : LSU response stage - collects one or two beats, aligns load
//               data and holds the result for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_out
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [1:0]  lsu_addr_offset_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    input  logic        wb_ready_i,
    output logic        lsu_busy_o
);

    localparam logic [1:0] c_IDLE    = ST_IDLE;
    localparam logic [1:0] c_WAIT_LO = ST_WAIT_LO;
    localparam logic [1:0] c_WAIT_HI = ST_WAIT_HI;
    localparam logic [1:0] c_HOLD    = ST_HOLD;

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_type;
    logic        r_sign_ext;
    logic [1:0]  r_offset;
    logic        r_split;
    logic [31:0] r_lo;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_err_out;

    logic [31:0] w_align_lo;
    logic [31:0] w_align_hi;
    logic [31:0] w_aligned;
    logic        w_err_next;
    logic        w_enter_hold;

    // The final beat is consumed straight off the bus so the result is ready on HOLD entry.
    assign w_align_lo   = (r_state == c_WAIT_LO) ? data_rdata_i : r_lo;
    assign w_align_hi   = (r_state == c_WAIT_HI) ? data_rdata_i : 32'd0;
    assign w_err_next   = r_err | data_err_i;
    assign w_enter_hold = data_rvalid_i &&
                          (((r_state == c_WAIT_LO) && !r_split) || (r_state == c_WAIT_HI));

    lsu_rdata_align u_align (
        .hi       (w_align_hi),
        .lo       (w_align_lo),
        .offset   (r_offset),
        .typ      (r_type),
        .sign_ext (r_sign_ext),
        .result   (w_aligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_we       <= 1'b0;
            r_type     <= 2'd0;
            r_sign_ext <= 1'b0;
            r_offset   <= 2'd0;
            r_split    <= 1'b0;
            r_lo       <= 32'd0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_err_out  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (lsu_req_valid_i) begin
                        r_we       <= lsu_we_i;
                        r_type     <= lsu_type_i;
                        r_sign_ext <= lsu_sign_ext_i;
                        r_offset   <= lsu_addr_offset_i;
                        r_split    <= !lsu_we_i && lsu_is_split(lsu_type_i, lsu_addr_offset_i);
                        r_state    <= c_WAIT_LO;
                    end
                end
                c_WAIT_LO: begin
                    if (data_rvalid_i) begin
                        r_lo    <= data_rdata_i;
                        r_err   <= w_err_next;
                        r_state <= r_split ? c_WAIT_HI : c_HOLD;
                    end
                end
                c_WAIT_HI: begin
                    if (data_rvalid_i) begin
                        r_err   <= w_err_next;
                        r_state <= c_HOLD;
                    end
                end
                default: begin
                    if (wb_ready_i) begin
                        r_err   <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
            endcase

            if (w_enter_hold) begin
                r_rdata   <= (r_we || w_err_next) ? 32'd0 : w_aligned;
                r_err_out <= w_err_next;
            end
        end
    end

    assign lsu_req_ready_o = (r_state == c_IDLE);
    assign lsu_busy_o      = (r_state != c_IDLE);
    assign lsu_rvalid_o    = (r_state == c_HOLD);
    assign lsu_rdata_o     = r_rdata;
    assign lsu_err_o       = r_err_out;

endmodule

`default_nettype wire

// File: tb/tb_lsu_out.sv
// ============================================================================
// Module      : tb_lsu_out
// Description : Directed vector bench for the LSU response stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_out;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [1:0]  lsu_addr_offset_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        wb_ready_i;
    logic        lsu_busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    lsu_out dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .lsu_req_valid_i   (lsu_req_valid_i),
        .lsu_req_ready_o   (lsu_req_ready_o),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .lsu_addr_offset_i (lsu_addr_offset_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_rdata_i      (data_rdata_i),
        .data_err_i        (data_err_i),
        .lsu_rvalid_o      (lsu_rvalid_o),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_err_o         (lsu_err_o),
        .wb_ready_i        (wb_ready_i),
        .lsu_busy_o        (lsu_busy_o)
    );

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sx;
        logic [1:0]  off;
        logic        two_beats;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err_lo;
        logic        err_hi;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        lsu_req_valid_i   = 1'b0;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'b00;
        lsu_sign_ext_i    = 1'b0;
        lsu_addr_offset_i = 2'b00;
        data_rvalid_i     = 1'b0;
        data_rdata_i      = 32'd0;
        data_err_i        = 1'b0;
        wb_ready_i        = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] typ, input logic sx, input logic [1:0] off);
        lsu_req_valid_i   = 1'b1;
        lsu_we_i          = we;
        lsu_type_i        = typ;
        lsu_sign_ext_i    = sx;
        lsu_addr_offset_i = off;
        tick();
        lsu_req_valid_i   = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic e);
        data_rvalid_i = 1'b1;
        data_rdata_i  = d;
        data_err_i    = e;
        tick();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'd0;
        data_err_i    = 1'b0;
    endtask

    task automatic handshake(input string name);
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        check({name, " rvalid after handshake"}, {31'd0, lsu_rvalid_o}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        issue(v.we, v.typ, v.sx, v.off);
        check({nm, " ready in WAIT_LO"}, {31'd0, lsu_req_ready_o}, 32'd0);
        beat(v.lo, v.err_lo);
        if (v.two_beats) begin
            check({nm, " rvalid before hi beat"}, {31'd0, lsu_rvalid_o}, 32'd0);
            beat(v.hi, v.err_hi);
        end
        check({nm, " rvalid"}, {31'd0, lsu_rvalid_o}, 32'd1);
        check({nm, " rdata"}, lsu_rdata_o, v.exp_data);
        check({nm, " err"}, {31'd0, lsu_err_o}, {31'd0, v.exp_err});
        handshake(nm);
    endtask

    initial begin
        //            we    typ    sx    off   2beat lo            hi            elo   ehi   exp           eerr
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b1, 2'd3, 1'b0, 32'h80112233, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 2'd2, 1'b0, 32'h80112233, 32'h0,        1'b0, 1'b0, 32'h00008011, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 32'h44332211, 32'h88776655, 1'b0, 1'b0, 32'h55443322, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 2'd2, 1'b1, 32'h11223344, 32'h55667788, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 2'd3, 1'b1, 32'h80AABBCC, 32'h000000F1, 1'b0, 1'b0, 32'hFFFFF180, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 32'h0000A500, 32'h0,        1'b0, 1'b0, 32'h000000A5, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 1'b1, 2'd1, 1'b0, 32'h0000A500, 32'h0,        1'b0, 1'b0, 32'hFFFFFFA5, 1'b0};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 2'd0, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 2'd0, 1'b0, 32'h12347FFF, 32'h0,        1'b0, 1'b1, 32'h00007FFF, 1'b0};

        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("reset rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
        check("reset rdata",  lsu_rdata_o, 32'd0);
        check("reset err",    {31'd0, lsu_err_o}, 32'd0);
        check("reset busy",   {31'd0, lsu_busy_o}, 32'd0);
        check("reset ready",  {31'd0, lsu_req_ready_o}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
            tick();
        end

        // Writeback stall: result must stay put until wb_ready.
        issue(1'b0, 2'b00, 1'b0, 2'd0);
        beat(32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d rvalid", i), {31'd0, lsu_rvalid_o}, 32'd1);
            check($sformatf("stall%0d rdata", i), lsu_rdata_o, 32'hDEADBEEF);
            tick();
        end
        handshake("stall");
        check("stall ready", {31'd0, lsu_req_ready_o}, 32'd1);
        check("stall rdata retained", lsu_rdata_o, 32'hDEADBEEF);

        // Split word with idle gaps between beats.
        issue(1'b0, 2'b00, 1'b0, 2'd1);
        beat(32'h44332211, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("gap%0d busy", i), {31'd0, lsu_busy_o}, 32'd1);
            check($sformatf("gap%0d rvalid", i), {31'd0, lsu_rvalid_o}, 32'd0);
            tick();
        end
        check("gap busy before hi", {31'd0, lsu_busy_o}, 32'd1);
        beat(32'h88776655, 1'b0);
        check("gap rvalid", {31'd0, lsu_rvalid_o}, 32'd1);
        check("gap busy in hold", {31'd0, lsu_busy_o}, 32'd1);
        check("gap rdata", lsu_rdata_o, 32'h55443322);
        handshake("gap");

        // Spurious responses while idle are dropped.
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hA5A5A5A5;
        data_err_i    = 1'b1;
        tick();
        tick();
        idle_inputs();
        check("spurious rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
        check("spurious busy",   {31'd0, lsu_busy_o}, 32'd0);
        check("spurious rdata",  lsu_rdata_o, 32'h55443322);
        check("spurious err",    {31'd0, lsu_err_o}, 32'd0);

        // Reset while waiting for the second beat.
        issue(1'b0, 2'b00, 1'b0, 2'd2);
        beat(32'h11111111, 1'b0);
        check("pre-reset busy", {31'd0, lsu_busy_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
        check("midrst rdata",  lsu_rdata_o, 32'd0);
        check("midrst err",    {31'd0, lsu_err_o}, 32'd0);
        check("midrst busy",   {31'd0, lsu_busy_o}, 32'd0);
        check("midrst ready",  {31'd0, lsu_req_ready_o}, 32'd1);
        beat(32'h22222222, 1'b0);
        check("late beat rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
        check("late beat busy",   {31'd0, lsu_busy_o}, 32'd0);
        check("late beat rdata",  lsu_rdata_o, 32'd0);

        // A fresh access after the reset must work normally.
        run_vec(vecs[1], 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
